// File: rtl/mem_arbiter.sv
// Purpose : two-port arbiter (port 0 CPU, port 1 DMA) in front of one memory,
//           with burst-limited tenures, lock extension and tie fairness.
// Latency : request-to-grant is one cycle from IDLE; the tenure handoff has no idle bubble.
// Backpressure: a port stalls while gntN=0; the memory path is combinational.
// Ports   : clk, reset (sync, active-high); req/lock/we/adr/wd per port in;
//           gnt/rd per port out; mem_we/mem_adr/mem_wd to memory, mem_rd from
//           memory; owner = registered state for debug.
module mem_arbiter #(
  parameter int MAXBURST = 4  // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] adr0,
  input  logic [31:0] adr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // bcnt value of the last cycle a tenure may take when the other port waits.
  localparam logic [3:0] BCNT_LAST = 4'(MAXBURST - 1);

  state_t     state_q;
  logic [3:0] bcnt_q;   // granted cycles so far in this tenure, saturating
  logic       last_q;   // port that most recently entered a tenure

  // Single FSM block. Every entry into OWNn clears bcnt and records n in
  // last, so a later tie from IDLE goes to the other port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= 4'd0;
      last_q  <= 1'b1;   // port 0 wins the first tie
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_q)) begin
            state_q <= OWN0;
            bcnt_q  <= 4'd0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= OWN1;
            bcnt_q  <= 4'd0;
            last_q  <= 1'b1;
          end
        end

        OWN0: begin
          if (req0) begin
            // Hand over only at the burst limit, without a lock, and only
            // when the other port actually wants the memory.
            if (!lock0 && (bcnt_q == BCNT_LAST) && req1) begin
              state_q <= OWN1;
              bcnt_q  <= 4'd0;
              last_q  <= 1'b1;
            end else if (bcnt_q != BCNT_LAST) begin
              bcnt_q <= bcnt_q + 4'd1;
            end
          end else if (req1) begin
            state_q <= OWN1;
            bcnt_q  <= 4'd0;
            last_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            bcnt_q  <= 4'd0;
          end
        end

        OWN1: begin
          if (req1) begin
            if (!lock1 && (bcnt_q == BCNT_LAST) && req0) begin
              state_q <= OWN0;
              bcnt_q  <= 4'd0;
              last_q  <= 1'b0;
            end else if (bcnt_q != BCNT_LAST) begin
              bcnt_q <= bcnt_q + 4'd1;
            end
          end else if (req0) begin
            state_q <= OWN0;
            bcnt_q  <= 4'd0;
            last_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            bcnt_q  <= 4'd0;
          end
        end

        default: begin
          state_q <= IDLE;
          bcnt_q  <= 4'd0;
        end
      endcase
    end
  end

  // Grants come from the registered owner qualified by the live request.
  // Reset masks them so an aborted tenure cannot issue a write in the very
  // cycle reset is applied.
  assign gnt0 = !reset && (state_q == OWN0) && req0;
  assign gnt1 = !reset && (state_q == OWN1) && req1;

  // Memory-side mux; all zero when nobody is granted so a stray we on a
  // waiting port never reaches the memory.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = 32'd0;
    mem_wd  = 32'd0;
    if (gnt0) begin
      mem_we  = we0;
      mem_adr = adr0;
      mem_wd  = wd0;
    end else if (gnt1) begin
      mem_we  = we1;
      mem_adr = adr1;
      mem_wd  = wd1;
    end
  end

  // Read data is broadcast; each port only consumes it when granted.
  assign rd0 = mem_rd;
  assign rd1 = mem_rd;

  // Debug view of the registered state, forced to IDLE while reset is held.
  assign owner = reset ? 2'b00 : state_q;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) !(gnt0 && gnt1));
  a_idle_quiet : assert property (@(posedge clk) (!gnt0 && !gnt1) |-> !mem_we);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter with a small memory model.
// Latency : inputs change 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: not applicable; fixed cycle counts, no open-ended waits.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] adr0, adr1, wd0, wd1;
  logic        gnt0, gnt1;
  logic [31:0] rd0, rd1;
  logic        mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic [1:0]  owner;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory model: 64 words, byte addresses 0x00..0xFC.
  logic [31:0] mem [0:63];
  logic        mem_clr;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;
  logic        adr_in_range;

  assign adr_in_range = (mem_adr[31:8] == 24'd0) && (mem_adr[1:0] == 2'b00);
  assign mem_rd = mem[mem_adr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (mem_we && adr_in_range) begin
      mem[mem_adr[7:2]] <= mem_wd;
    end
  end

  mem_arbiter #(.MAXBURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_dat = dat;
    tick;
    pl_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_idx = 6'd0; pl_dat = 32'd0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    adr0 = 0; adr1 = 0; wd0 = 0; wd1 = 0;
    tick;
    mem_clr = 1'b0;
    tick;

    // Requests and a write while reset is held: nothing may come out.
    req0 = 1; req1 = 1; we0 = 1; adr0 = 32'h54;
    @(negedge clk);
    check("rst_gnt0",   32'(gnt0),   0);
    check("rst_gnt1",   32'(gnt1),   0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_owner",  32'(owner),  0);
    check("rst_adr",    mem_adr,     0);
    tick;

    // Single write from port 0: one-cycle latency out of IDLE.
    reset = 0; req1 = 0; wd0 = 32'd7;
    @(negedge clk);
    check("c1_owner", 32'(owner),  0);
    check("c1_gnt0",  32'(gnt0),   0);
    check("c1_we",    32'(mem_we), 0);
    tick;
    @(negedge clk);
    check("c2_gnt0",  32'(gnt0),   1);
    check("c2_we",    32'(mem_we), 1);
    check("c2_adr",   mem_adr,     32'h54);
    check("c2_wd",    mem_wd,      32'd7);
    check("c2_owner", 32'(owner),  1);
    tick;
    req0 = 0; we0 = 0;
    @(negedge clk);
    check("rel_gnt0", 32'(gnt0),   0);
    check("rel_we",   32'(mem_we), 0);
    check("wr_mem21", mem[21],     32'd7);
    tick;
    @(negedge clk);
    check("rel_owner", 32'(owner), 0);

    // Fresh reset so the tie goes to port 0, then both ports hold requests.
    reset = 1;
    tick;
    reset = 0;
    preload(6'd8,  32'h0000A5A5);
    preload(6'd12, 32'h00001111);
    req0 = 1; req1 = 1; adr0 = 32'h10; adr1 = 32'h20;
    @(negedge clk);
    check("tie_idle_gnt0", 32'(gnt0), 0);
    check("tie_idle_gnt1", 32'(gnt1), 0);
    for (int i = 0; i < 16; i++) begin
      tick;
      @(negedge clk);
      check($sformatf("burst%0d_gnt0", i), 32'(gnt0), ((i / 4) % 2 == 0) ? 1 : 0);
      check($sformatf("burst%0d_gnt1", i), 32'(gnt1), ((i / 4) % 2 == 1) ? 1 : 0);
      if (i == 4) check("burst_rd1", rd1, 32'h0000A5A5);
    end

    // Port 1 tries to write while port 0 owns: the write must wait.
    tick;
    we1 = 1; adr1 = 32'h30; wd1 = 32'hDEAD;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("wait%0d_gnt0", j), 32'(gnt0), 1);
      check($sformatf("wait%0d_we", j),   32'(mem_we), 0);
      check($sformatf("wait%0d_mem12", j), mem[12], 32'h00001111);
      tick;
    end
    @(negedge clk);
    check("own1_gnt1", 32'(gnt1),  1);
    check("own1_we",   32'(mem_we), 1);
    check("own1_adr",  mem_adr,    32'h30);
    check("own1_wd",   mem_wd,     32'hDEAD);
    check("own1_mem12_pre", mem[12], 32'h00001111);

    // Port 1 drops its request while port 0 waits.
    tick;
    req1 = 0; we1 = 0;
    @(negedge clk);
    check("drop_mem12", mem[12],   32'h0000DEAD);
    check("drop_gnt1",  32'(gnt1), 0);
    check("drop_gnt0",  32'(gnt0), 0);
    check("drop_we",    32'(mem_we), 0);
    tick;
    @(negedge clk);
    check("hand_gnt0",  32'(gnt0),  1);
    check("hand_owner", 32'(owner), 1);
    tick;
    req0 = 0;
    @(negedge clk);
    check("end_gnt0", 32'(gnt0),   0);
    check("end_we",   32'(mem_we), 0);
    tick;
    @(negedge clk);
    check("end_owner", 32'(owner), 0);

    // Locked tenure on port 0 holds off port 1 past the burst limit.
    req0 = 1; lock0 = 1;
    tick;
    req1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lock%0d_gnt0", i), 32'(gnt0), 1);
      check($sformatf("lock%0d_gnt1", i), 32'(gnt1), 0);
      if (i < 9) tick;
    end
    tick;
    lock0 = 0;
    @(negedge clk);
    check("unlock_gnt0", 32'(gnt0), 1);
    tick;
    lock1 = 1; we1 = 1; adr1 = 32'h40; wd1 = 32'hBEEF;
    @(negedge clk);
    check("unlock_gnt1",  32'(gnt1),  1);
    check("unlock_owner", 32'(owner), 2);
    check("lockwr_we",    32'(mem_we), 1);

    // Reset in the middle of a locked port 1 write.
    tick;
    reset = 1; wd1 = 32'hCAFE;
    @(negedge clk);
    check("rstmid_we",    32'(mem_we), 0);
    check("rstmid_gnt1",  32'(gnt1),   0);
    check("rstmid_owner", 32'(owner),  0);
    tick;
    reset = 0; lock1 = 0; we1 = 0; adr0 = 32'h40;
    @(negedge clk);
    check("post_owner", 32'(owner), 0);
    check("post_gnt0",  32'(gnt0),  0);
    check("post_gnt1",  32'(gnt1),  0);
    check("post_mem16", mem[16],    32'h0000BEEF);
    tick;
    @(negedge clk);
    check("post_tie_gnt0", 32'(gnt0),  1);
    check("post_tie_gnt1", 32'(gnt1),  0);
    check("post_tie_owner", 32'(owner), 1);
    check("post_rd0",      rd0,        32'h0000BEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
